pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline boundary register that replaces the per-stage hand-written latches (if_id, id_ex, ex_mem, mem_wb) with one block.
- Carries an opaque payload bus plus a valid bit and a multi-cycle carry channel (madd/msub-style accumulator state).
- Honours the 6-bit stall vector and a flush, and reports how long the stage has been held.
- Sits between stage STAGE and stage STAGE+1 of the 5-stage core.

Parameters:
- STAGE, 3, index into stall[] of the upstream stage; legal 0..4; downstream stage is STAGE+1.
- DATA_W, 64, payload width in bits, 1..512.
- NOP_VALUE, 0, DATA_W-bit payload value loaded on reset, bubble or flush.
- CARRY_W, 66, width of the carry channel (cnt + hilo_temp style).
- HOLD_W, 4, width of the saturating hold-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- stall  in  6  stall vector; bit k = 1 (Stop) stalls stage k
- flush  in  1  exception or eret flush; kills the stage contents
- in_valid  in  1  upstream holds a real instruction
- in_payload  in  DATA_W  upstream stage results
- in_carry  in  CARRY_W  multi-cycle state fed back from the upstream stage
- out_valid  out  1  downstream holds a real instruction
- out_payload  out  DATA_W  registered payload
- out_carry  out  CARRY_W  registered carry state returned to the upstream stage
- out_hold  out  HOLD_W  consecutive cycles the stage has been held, saturating
- out_bubble  out  1  pulses high for one cycle, the cycle after a bubble was inserted

Behaviour:
- Reset (rst = 0, asynchronous):
  - out_valid = 0, out_payload = NOP_VALUE, out_carry = 0, out_hold = 0, out_bubble = 0.
  - Counters clear too when the optional feature is compiled in.
  - Deassertion is sampled on the next clk edge.
- Modes are evaluated each rising edge in this priority order:
  1. FLUSH (flush = 1, regardless of stall):
     - out_valid = 0, out_payload = NOP_VALUE, out_carry = 0, out_hold = 0, out_bubble = 0.
  2. BUBBLE (stall[STAGE] = 1 and stall[STAGE+1] = 0):
     - out_valid = 0, out_payload = NOP_VALUE.
     - out_carry = in_carry, so accumulator state survives the stall.
     - out_hold = 0, out_bubble = 1.
  3. ADVANCE (stall[STAGE] = 0):
     - out_valid = in_valid, out_payload = in_payload.
     - out_carry = 0 (multi-cycle op completed or never started).
     - out_hold = 0, out_bubble = 0.
  4. HOLD (stall[STAGE] = 1 and stall[STAGE+1] = 1):
     - out_valid and out_payload unchanged.
     - out_carry = in_carry.
     - out_hold = out_hold + 1, saturating at 2^HOLD_W - 1 (no wrap).
     - out_bubble = 0.
- Latency: one cycle from in_* to out_* in ADVANCE mode. No combinational path from any input to any output.
- When in_valid = 0 in ADVANCE, out_payload still takes in_payload; consumers qualify with out_valid.
- out_bubble is registered; it is high only in the cycle following a BUBBLE edge.
- Consecutive BUBBLE edges hold out_bubble high on each following cycle.
- Reset asserted mid-HOLD clears everything immediately; no partial carry state survives.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt [31:0] and perf_bubble_cnt [31:0].
  - perf_stall_cnt increments on every HOLD edge; perf_bubble_cnt increments on every BUBBLE edge.
  - Both wrap modulo 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: the ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 5 ADVANCE edges with in_payload = 1..5, in_valid = 1 -> out_payload = 1..5 one cycle late, out_valid = 1, out_carry = 0.
- STAGE = 3, stall = 6'b001111 for 1 edge with in_carry = 66'h2_DEAD_BEEF_0000_0001 -> out_valid = 0, out_payload = NOP_VALUE, out_carry = in_carry, out_bubble = 1 on the next cycle.
- STAGE = 3, out_payload = 0xAB, stall = 6'b011111 for 20 edges -> out_payload stays 0xAB, out_hold counts 1..15 then stays 15, out_carry follows in_carry.
- flush = 1 together with stall = 6'b011111 while holding 0xAB -> out_valid = 0, out_payload = NOP_VALUE, out_carry = 0, out_hold = 0.
- rst low asynchronously mid-cycle during HOLD with out_hold = 7 -> all outputs reach reset values before the next clk edge; first ADVANCE after release loads in_payload.
- With PIPE_STAGE_PERF_EN defined: 3 HOLD edges, 2 BUBBLE edges, 1 flush -> perf_stall_cnt = 3, perf_bubble_cnt = 2; undefined build elaborates with no perf_* ports.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: payload, valid, carry channel, hold counter.
// Optional perf counters under PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int                STAGE     = 3,
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CARRY_W   = 66,
  parameter int                HOLD_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic [CARRY_W-1:0] in_carry,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic [CARRY_W-1:0] out_carry,
  output logic [HOLD_W-1:0]  out_hold,
  output logic               out_bubble
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  localparam logic [2:0] UP = 3'(STAGE);
  localparam logic [2:0] DN = 3'(STAGE + 1);

  logic up_stop;
  logic dn_stop;
  logic do_flush;
  logic do_bubble;
  logic do_adv;
  logic do_hold;

  always_comb begin
    up_stop   = stall[UP];
    dn_stop   = stall[DN];
    do_flush  = flush;
    do_bubble = !flush && up_stop && !dn_stop;
    do_adv    = !flush && !up_stop;
    do_hold   = !flush && up_stop && dn_stop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_payload <= NOP_VALUE;
      out_carry   <= '0;
      out_hold    <= '0;
      out_bubble  <= 1'b0;
    end else begin
      unique case (1'b1)
        do_flush: begin
          out_valid   <= 1'b0;
          out_payload <= NOP_VALUE;
          out_carry   <= '0;
          out_hold    <= '0;
          out_bubble  <= 1'b0;
        end
        do_bubble: begin
          out_valid   <= 1'b0;
          out_payload <= NOP_VALUE;
          out_carry   <= in_carry;
          out_hold    <= '0;
          out_bubble  <= 1'b1;
        end
        do_adv: begin
          out_valid   <= in_valid;
          out_payload <= in_payload;
          out_carry   <= '0;
          out_hold    <= '0;
          out_bubble  <= 1'b0;
        end
        do_hold: begin
          out_carry  <= in_carry;
          out_bubble <= 1'b0;
          // saturate rather than wrap so long stalls stay visible
          if (out_hold != '1)
            out_hold <= out_hold + 1'b1;
        end
        default: begin
          out_bubble <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (do_hold)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (do_bubble)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (default parameters, STAGE = 3).
// Perf counter checks compile only with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_payload;
  logic [65:0] in_carry;
  logic        out_valid;
  logic [63:0] out_payload;
  logic [65:0] out_carry;
  logic [3:0]  out_hold;
  logic        out_bubble;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int tests;
  int fails;

  pipe_stage_reg dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_payload  (in_payload),
    .in_carry    (in_carry),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_carry   (out_carry),
    .out_hold    (out_hold),
    .out_bubble  (out_bubble)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        valid;
    logic [63:0] payload;
    logic [65:0] carry;
    logic        e_valid;
    logic [63:0] e_payload;
    logic [65:0] e_carry;
    logic [3:0]  e_hold;
    logic        e_bubble;
  } vec_t;

  localparam int NV = 10;
  vec_t v [NV];

  localparam logic [65:0] CDEAD = 66'h2_DEAD_BEEF_0000_0001;

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ev,
                         input logic [63:0] ep, input logic [65:0] ec,
                         input logic [3:0] eh, input logic eb);
    chk({name, ".valid"},   96'(out_valid),   96'(ev));
    chk({name, ".payload"}, 96'(out_payload), 96'(ep));
    chk({name, ".carry"},   96'(out_carry),   96'(ec));
    chk({name, ".hold"},    96'(out_hold),    96'(eh));
    chk({name, ".bubble"},  96'(out_bubble),  96'(eb));
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic iv,
                       input logic [63:0] p, input logic [65:0] c);
    stall      = s;
    flush      = f;
    in_valid   = iv;
    in_payload = p;
    in_carry   = c;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] s, input logic f,
                              input logic iv, input logic [63:0] p,
                              input logic [65:0] c, input logic ev,
                              input logic [63:0] ep, input logic [65:0] ec,
                              input logic [3:0] eh, input logic eb);
    vec_t r;
    r.stall = s; r.flush = f; r.valid = iv; r.payload = p; r.carry = c;
    r.e_valid = ev; r.e_payload = ep; r.e_carry = ec;
    r.e_hold = eh; r.e_bubble = eb;
    return r;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    drive(6'b0, 1'b0, 1'b0, 64'h0, 66'h0);

    for (int i = 0; i < 5; i++)
      v[i] = mk(6'b0, 0, 1, 64'(i + 1), 66'h3, 1, 64'(i + 1), 66'h0, 0, 0);
    v[5] = mk(6'b0, 0, 0, 64'h77, 66'h0, 0, 64'h77, 66'h0, 0, 0);
    v[6] = mk(6'b0, 0, 1, 64'hAB, 66'h0, 1, 64'hAB, 66'h0, 0, 0);
    v[7] = mk(6'b001111, 0, 1, 64'h99, CDEAD, 0, 64'h0, CDEAD, 0, 1);
    v[8] = mk(6'b001111, 0, 1, 64'h98, 66'h5, 0, 64'h0, 66'h5, 0, 1);
    v[9] = mk(6'b000111, 0, 1, 64'hAB, 66'h5, 1, 64'hAB, 66'h0, 0, 0);

    #3;
    chk_all("reset", 0, 64'h0, 66'h0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(v[i].stall, v[i].flush, v[i].valid, v[i].payload, v[i].carry);
      step();
      chk_all($sformatf("vec%0d", i), v[i].e_valid, v[i].e_payload,
              v[i].e_carry, v[i].e_hold, v[i].e_bubble);
    end

    // 20 HOLD edges: hold counts 1..15 then saturates
    for (int i = 0; i < 20; i++) begin
      drive(6'b011111, 0, 0, 64'h11, 66'(i + 100));
      step();
      chk_all($sformatf("hold%0d", i), 1, 64'hAB, 66'(i + 100),
              4'((i + 1 > 15) ? 15 : i + 1), 0);
    end

    drive(6'b011111, 1, 1, 64'h11, CDEAD);
    step();
    chk_all("flush_hold", 0, 64'h0, 66'h0, 0, 0);

    drive(6'b001111, 1, 1, 64'h11, CDEAD);
    step();
    chk_all("flush_bubble", 0, 64'h0, 66'h0, 0, 0);

    drive(6'b0, 0, 1, 64'hAB, 66'h0);
    step();
    chk_all("reload", 1, 64'hAB, 66'h0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      drive(6'b111111, 0, 0, 64'h0, 66'h3C);
      step();
    end
    chk_all("hold7", 1, 64'hAB, 66'h3C, 7, 0);

    #1;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 64'h0, 66'h0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(6'b0, 0, 1, 64'h55, 66'h1);
    step();
    chk_all("post_rst", 1, 64'h55, 66'h0, 0, 0);

`ifdef PIPE_STAGE_PERF_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("perf_rst_stall", 96'(perf_stall_cnt), 96'd0);
    chk("perf_rst_bubble", 96'(perf_bubble_cnt), 96'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(6'b011000, 0, 0, 64'h0, 66'h0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(6'b001000, 0, 0, 64'h0, 66'h0);
      step();
    end
    drive(6'b011000, 1, 0, 64'h0, 66'h0);
    step();
    chk("perf_stall", 96'(perf_stall_cnt), 96'd3);
    chk("perf_bubble", 96'(perf_bubble_cnt), 96'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
